// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: merges pipeline writeback with
// buffered multi-cycle unit results into one registered wa/wd/we port.
//
// Ports:
//   cpu_clk_50M, cpu_rst_n     clock, async active-low reset
//   pipe_wa/pipe_wd/pipe_we    in-order pipeline writeback
//   pipe_stall                 pipeline must hold its writeback this cycle
//   mcu_valid/mcu_ready        multi-cycle result handshake
//   mcu_wa/mcu_wd              multi-cycle result address/data
//   busy_mask                  registers with a write pending in the FIFO
//   wa/wd/we                   registered register-file write port
module wb_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic        pipe_we,
    input  logic        mcu_valid,
    output logic        mcu_ready,
    input  logic [4:0]  mcu_wa,
    input  logic [31:0] mcu_wd,
    output logic        pipe_stall,
    output logic [31:0] busy_mask,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic        we
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [4:0]    fifo_wa [DEPTH];
    logic [31:0]   fifo_wd [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [SW-1:0] starve_cnt;

    logic          fifo_empty;
    logic          pipe_real;
    logic          enq;
    logic          deq;

    assign fifo_empty = (count == '0);
    assign mcu_ready  = cpu_rst_n && (count < FULL);
    assign pipe_stall = (starve_cnt == SMAX);
    assign pipe_real  = pipe_we && (pipe_wa != 5'd0) && !pipe_stall;

    // Address-0 results complete the handshake but are never stored.
    assign enq = mcu_valid && mcu_ready && (mcu_wa != 5'd0);

    // The FIFO only drains in slots the pipeline leaves idle; a stall
    // frees such a slot because pipe_real is masked by pipe_stall.
    assign deq = !pipe_real && !fifo_empty;

    // Result storage: contents are meaningless outside [head, head+count)
    // so no reset is needed.
    always_ff @(posedge cpu_clk_50M) begin
        if (enq) begin
            fifo_wa[tail] <= mcu_wa;
            fifo_wd[tail] <= mcu_wd;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            unique case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            starve_cnt <= '0;
        end else if (deq || fifo_empty) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SMAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // wa/wd hold their last value on idle slots; only we drops.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            we <= 1'b0;
            wa <= 5'd0;
            wd <= 32'd0;
        end else if (pipe_real) begin
            we <= 1'b1;
            wa <= pipe_wa;
            wd <= pipe_wd;
        end else if (deq) begin
            we <= 1'b1;
            wa <= fifo_wa[head];
            wd <= fifo_wd[head];
        end else begin
            we <= 1'b0;
        end
    end

    // An entry at slot i is live when its distance from head is below
    // count. The word on the output register is excluded: read bypass
    // on ra==wa already covers it.
    always_comb begin
        logic [AW-1:0] off;
        busy_mask = 32'd0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - head;
            if ({1'b0, off} < count) begin
                busy_mask[fifo_wa[i]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter.
module tb_wb_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        pipe_we;
    logic        mcu_valid;
    logic        mcu_ready;
    logic [4:0]  mcu_wa;
    logic [31:0] mcu_wd;
    logic        pipe_stall;
    logic [31:0] busy_mask;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;

    int checks;
    int failures;

    wb_write_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .pipe_wa     (pipe_wa),
        .pipe_wd     (pipe_wd),
        .pipe_we     (pipe_we),
        .mcu_valid   (mcu_valid),
        .mcu_ready   (mcu_ready),
        .mcu_wa      (mcu_wa),
        .mcu_wd      (mcu_wd),
        .pipe_stall  (pipe_stall),
        .busy_mask   (busy_mask),
        .wa          (wa),
        .wd          (wd),
        .we          (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pipe_we = 1'b0; pipe_wa = 5'd0; pipe_wd = 32'd0;
        mcu_valid = 1'b0; mcu_wa = 5'd0; mcu_wd = 32'd0;
        #12;
        checks++;
        if ({we, wa, wd} !== {1'b0, 5'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_port got we=%b wa=%0d wd=%h want 0/0/0", we, wa, wd);
        end
        checks++;
        if ({mcu_ready, pipe_stall, busy_mask} !== 34'd0) begin
            failures++;
            $display("FAIL reset_ctl got ready=%b stall=%b busy=%h want 0/0/0",
                     mcu_ready, pipe_stall, busy_mask);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (mcu_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b want 1", mcu_ready);
        end
    endtask

    task automatic test_pipe_write();
        pipe_we = 1'b1; pipe_wa = 5'd5; pipe_wd = 32'h12345678;
        tick();
        checks++;
        if ({we, wa, wd} !== {1'b1, 5'd5, 32'h12345678}) begin
            failures++;
            $display("FAIL pipe_write got we=%b wa=%0d wd=%h want 1/5/12345678", we, wa, wd);
        end
        pipe_we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({we, wa} !== {1'b0, 5'd0}) begin
            failures++;
            $display("FAIL async_reset got we=%b wa=%0d want 0/0", we, wa);
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mcu_single();
        mcu_valid = 1'b1; mcu_wa = 5'd7; mcu_wd = 32'hDEADBEEF;
        checks++;
        if (mcu_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got %b want 1", mcu_ready);
        end
        tick();
        mcu_valid = 1'b0;
        checks++;
        if ({busy_mask, we} !== {32'h80, 1'b0}) begin
            failures++;
            $display("FAIL single_busy got busy=%h we=%b want 80/0", busy_mask, we);
        end
        tick();
        checks++;
        if ({we, wa, wd} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL single_write got we=%b wa=%0d wd=%h want 1/7/deadbeef", we, wa, wd);
        end
        checks++;
        if (busy_mask !== 32'd0) begin
            failures++;
            $display("FAIL single_clear got busy=%h want 0", busy_mask);
        end
    endtask

    task automatic test_starve();
        pipe_we = 1'b1; pipe_wa = 5'd9; pipe_wd = 32'h99;
        mcu_valid = 1'b1; mcu_wa = 5'd3; mcu_wd = 32'h33;
        tick();
        mcu_wa = 5'd4; mcu_wd = 32'h44;
        checks++;
        if (mcu_ready !== 1'b1) begin
            failures++;
            $display("FAIL starve_ready1 got %b want 1", mcu_ready);
        end
        tick();
        mcu_valid = 1'b0;
        checks++;
        if ({mcu_ready, pipe_stall, busy_mask} !== {1'b0, 1'b0, 32'h18}) begin
            failures++;
            $display("FAIL starve_full got ready=%b stall=%b busy=%h want 0/0/18",
                     mcu_ready, pipe_stall, busy_mask);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (pipe_stall !== 1'b0) begin
                failures++;
                $display("FAIL starve_early k=%0d got stall=%b want 0", k, pipe_stall);
            end
        end
        tick();
        checks++;
        if ({pipe_stall, we, wa} !== {1'b1, 1'b1, 5'd9}) begin
            failures++;
            $display("FAIL starve_stall got stall=%b we=%b wa=%0d want 1/1/9",
                     pipe_stall, we, wa);
        end
        tick();
        pipe_we = 1'b0;
        checks++;
        if ({we, wa, wd} !== {1'b1, 5'd3, 32'h33}) begin
            failures++;
            $display("FAIL starve_drain got we=%b wa=%0d wd=%h want 1/3/33", we, wa, wd);
        end
        checks++;
        if ({mcu_ready, pipe_stall, busy_mask} !== {1'b1, 1'b0, 32'h10}) begin
            failures++;
            $display("FAIL starve_after got ready=%b stall=%b busy=%h want 1/0/10",
                     mcu_ready, pipe_stall, busy_mask);
        end
        tick();
        checks++;
        if ({we, wa, wd, busy_mask} !== {1'b1, 5'd4, 32'h44, 32'd0}) begin
            failures++;
            $display("FAIL starve_second got we=%b wa=%0d wd=%h busy=%h want 1/4/44/0",
                     we, wa, wd, busy_mask);
        end
        tick();
        checks++;
        if ({we, wa, wd} !== {1'b0, 5'd4, 32'h44}) begin
            failures++;
            $display("FAIL idle_hold got we=%b wa=%0d wd=%h want 0/4/44", we, wa, wd);
        end
    endtask

    task automatic test_zero_addr();
        mcu_valid = 1'b1; mcu_wa = 5'd0; mcu_wd = 32'hBAD;
        pipe_we = 1'b1; pipe_wa = 5'd0; pipe_wd = 32'hBAD0;
        checks++;
        if (mcu_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_ready got %b want 1", mcu_ready);
        end
        tick();
        mcu_valid = 1'b0;
        pipe_we = 1'b0;
        checks++;
        if ({busy_mask, mcu_ready, we} !== {32'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL zero_store got busy=%h ready=%b we=%b want 0/1/0",
                     busy_mask, mcu_ready, we);
        end
        tick();
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL zero_we got %b want 0", we);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] r;
        mcu_valid = 1'b1; mcu_wa = 5'd10; mcu_wd = 32'h10A;
        tick();
        checks++;
        if ({busy_mask, we} !== {32'h400, 1'b0}) begin
            failures++;
            $display("FAIL b2b_first got busy=%h we=%b want 400/0", busy_mask, we);
        end
        for (int k = 1; k < 6; k++) begin
            r = 5'(10 + k);
            mcu_wa = r;
            mcu_wd = 32'h100 + 32'(r);
            tick();
            checks++;
            if ({we, wa, wd} !== {1'b1, r - 5'd1, 32'h100 + 32'(r) - 32'd1}) begin
                failures++;
                $display("FAIL b2b_order k=%0d got we=%b wa=%0d wd=%h want 1/%0d/%h",
                         k, we, wa, wd, r - 5'd1, 32'h100 + 32'(r) - 32'd1);
            end
            checks++;
            if ({busy_mask, mcu_ready} !== {32'd1 << r, 1'b1}) begin
                failures++;
                $display("FAIL b2b_count k=%0d got busy=%h ready=%b want %h/1",
                         k, busy_mask, mcu_ready, 32'd1 << r);
            end
        end
        mcu_valid = 1'b0;
        tick();
        checks++;
        if ({we, wa, wd, busy_mask} !== {1'b1, 5'd15, 32'h10F, 32'd0}) begin
            failures++;
            $display("FAIL b2b_last got we=%b wa=%0d wd=%h busy=%h want 1/15/10f/0",
                     we, wa, wd, busy_mask);
        end
    endtask

    task automatic test_reset_flush();
        pipe_we = 1'b1; pipe_wa = 5'd9; pipe_wd = 32'h99;
        mcu_valid = 1'b1; mcu_wa = 5'd20; mcu_wd = 32'h20;
        tick();
        mcu_wa = 5'd21; mcu_wd = 32'h21;
        tick();
        mcu_valid = 1'b0;
        checks++;
        if (busy_mask !== 32'h0030_0000) begin
            failures++;
            $display("FAIL flush_pre got busy=%h want 00300000", busy_mask);
        end
        rst_n = 1'b0;
        pipe_we = 1'b0;
        #1;
        checks++;
        if ({we, busy_mask, mcu_ready} !== {1'b0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL flush_rst got we=%b busy=%h ready=%b want 0/0/0",
                     we, busy_mask, mcu_ready);
        end
        tick();
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if ({we, busy_mask, mcu_ready} !== {1'b0, 32'd0, 1'b1}) begin
            failures++;
            $display("FAIL flush_rel got we=%b busy=%h ready=%b want 0/0/1",
                     we, busy_mask, mcu_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (we !== 1'b0) begin
                failures++;
                $display("FAIL flush_stale k=%0d got we=%b wa=%0d want we=0", k, we, wa);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_pipe_write();
        test_mcu_single();
        test_starve();
        test_zero_addr();
        test_back_to_back();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
